// File: rtl/mdom_wvb_writer.sv
// Waveform-buffer writer: a pre-trigger delay line feeds a capture FSM that streams
// one triggered waveform into the buffer, followed by a single header word.
module mdom_wvb_writer #(
   parameter int P_PRE_DEPTH = 32,
   parameter int P_LTC_W     = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [11:0]          adc_stream_in,
   input  logic [7:0]           discr_stream_in,
   input  logic                 trig,
   input  logic [1:0]           trig_src,
   input  logic [P_LTC_W-1:0]   ltc,
   input  logic [4:0]           pre_conf,
   input  logic [11:0]          post_conf,
   input  logic                 wvb_full,
   input  logic                 ovf_clr,
   output logic [19:0]          wvb_data,
   output logic                 wvb_wr_en,
   output logic                 wvb_eoe,
   output logic [P_LTC_W+14:0]  hdr_data,
   output logic                 hdr_wr_en,
   output logic                 busy,
   output logic                 overflow,
   output logic [15:0]          trig_cnt
);

   localparam int AW = $clog2(P_PRE_DEPTH);
   localparam logic [AW-1:0] FILL_LAST = AW'(P_PRE_DEPTH - 1);

   typedef enum logic [1:0] {
      S_FILL,
      S_IDLE,
      S_CAPTURE,
      S_HEADER
   } state_t;

   state_t              state;
   logic [19:0]         dline [P_PRE_DEPTH];
   logic [AW-1:0]       fill_cnt;
   logic [AW-1:0]       tap_sel;
   logic [12:0]         remaining;
   logic [12:0]         n_lat;
   logic [1:0]          src_lat;
   logic [P_LTC_W-1:0]  ltc_lat;
   logic [12:0]         n_new;

   assign n_new = 13'(pre_conf) + 13'(post_conf) + 13'd1;

   // dline[k] holds the sample presented k+1 edges ago, so tap pre_conf read one
   // edge after acceptance yields the sample pre_conf cycles before the trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < P_PRE_DEPTH; k++) begin
            dline[k] <= '0;
         end
      end else begin
         dline[0] <= {discr_stream_in, adc_stream_in};
         for (int k = 1; k < P_PRE_DEPTH; k++) begin
            dline[k] <= dline[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FILL;
         fill_cnt  <= '0;
         tap_sel   <= '0;
         remaining <= '0;
         n_lat     <= '0;
         src_lat   <= '0;
         ltc_lat   <= '0;
         wvb_data  <= '0;
         wvb_wr_en <= 1'b0;
         wvb_eoe   <= 1'b0;
         hdr_data  <= '0;
         hdr_wr_en <= 1'b0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
         trig_cnt  <= '0;
      end else begin
         wvb_wr_en <= 1'b0;
         wvb_eoe   <= 1'b0;
         hdr_wr_en <= 1'b0;
         // A drop later in this block overrides the clear.
         if (ovf_clr) begin
            overflow <= 1'b0;
         end
         case (state)
            S_FILL: begin
               fill_cnt <= fill_cnt + 1'b1;
               if (fill_cnt == FILL_LAST) begin
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (trig) begin
                  if (wvb_full) begin
                     overflow <= 1'b1;
                  end else begin
                     src_lat   <= trig_src;
                     ltc_lat   <= ltc;
                     tap_sel   <= AW'(pre_conf);
                     n_lat     <= n_new;
                     remaining <= n_new;
                     trig_cnt  <= trig_cnt + 16'd1;
                     busy      <= 1'b1;
                     state     <= S_CAPTURE;
                  end
               end
            end
            S_CAPTURE: begin
               wvb_wr_en <= 1'b1;
               wvb_data  <= dline[tap_sel];
               remaining <= remaining - 13'd1;
               if (remaining == 13'd1) begin
                  wvb_eoe <= 1'b1;
                  state   <= S_HEADER;
               end
            end
            S_HEADER: begin
               hdr_wr_en <= 1'b1;
               hdr_data  <= {src_lat, ltc_lat, n_lat};
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_FILL;
            end
         endcase
      end
   end

endmodule
